// File: rtl/cpu_defs.sv
// Shared definitions for the MUL/DIV sequencer: FSM states and
// the LO value returned for a fast divide-by-zero.
package cpu_defs;

  typedef enum logic [2:0] {
    IDLE,
    MUL_BUSY,
    DIV_BUSY,
    DONE,
    DRAIN
  } muldiv_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_watchdog.sv
// Wait-cycle watchdog for the MUL/DIV sequencer.
// Ports: clear/run/ack from the FSM, expire pulse, sticky timeout_err.
module muldiv_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic expire,
  output logic timeout_err
);

  logic [CNT_W-1:0] cnt;

  // Fires in the TIMEOUT-th waiting cycle unless the unit answers.
  assign expire = run & ~ack &
                  (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the multi-cycle multiplier/divider units.
// Ports: EX request/flush/hold in, unit issue/result, stall/done/hi/lo out.
// Option: MULDIV_DIV0_FAST_EN answers divide-by-zero without the divider.
module muldiv_ctrl
  import cpu_defs::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mul,
  input  logic        req_div,
  input  logic        req_sign,
  input  logic [31:0] req_srca,
  input  logic [31:0] req_srcb,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        mul_in_valid,
  output logic        div_in_valid,
  output logic        unit_sign,
  output logic [31:0] unit_srca,
  output logic [31:0] unit_srcb,
  input  logic        mul_out_valid,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic        div_out_valid,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        timeout_err
);

  muldiv_state_t state, state_nxt;

  logic drain_div;
  logic issue_mul, issue_div, fast0;
  logic take, clear;
  logic busy, run, ack, expire;
  logic unit_div, unit_valid;
  logic req_any, div0;

`ifdef MULDIV_DIV0_FAST_EN
  assign div0 = (req_srcb == '0);
`else
  assign div0 = 1'b0;
`endif

  assign req_any = req_mul | req_div;
  assign busy    = (state == MUL_BUSY) ||
                   (state == DIV_BUSY);
  assign run     = busy || (state == DRAIN);

  // Unit currently owed a result: the busy one,
  // or the one being drained after a flush.
  assign unit_div   = (state == DIV_BUSY) ||
                      ((state == DRAIN) && drain_div);
  assign unit_valid = unit_div ? div_out_valid
                               : mul_out_valid;
  assign ack        = unit_valid | (busy & flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue_mul = 1'b0;
    issue_div = 1'b0;
    fast0     = 1'b0;
    take      = 1'b0;
    clear     = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req_any & ~flush;
        if (!flush) begin
          if (req_mul) begin
            issue_mul = 1'b1;
            clear     = 1'b1;
            state_nxt = MUL_BUSY;
          end else if (req_div && div0) begin
            fast0     = 1'b1;
            state_nxt = DONE;
          end else if (req_div) begin
            issue_div = 1'b1;
            clear     = 1'b1;
            state_nxt = DIV_BUSY;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        stall = req_any & ~flush;
        if (flush && unit_valid) begin
          state_nxt = IDLE;
        end else if (flush) begin
          clear     = 1'b1;
          state_nxt = DRAIN;
        end else if (unit_valid) begin
          take      = 1'b1;
          state_nxt = DONE;
        end else if (expire) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (flush || !ex_hold) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        stall = req_any & ~flush;
        if (unit_valid || expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_in_valid <= 1'b0;
      div_in_valid <= 1'b0;
      unit_sign    <= 1'b0;
      unit_srca    <= '0;
      unit_srcb    <= '0;
      hi_out       <= '0;
      lo_out       <= '0;
      drain_div    <= 1'b0;
    end else begin
      mul_in_valid <= issue_mul;
      div_in_valid <= issue_div;
      if (issue_mul || issue_div) begin
        unit_sign <= req_sign;
        unit_srca <= req_srca;
        unit_srcb <= req_srcb;
      end
      if (take) begin
        hi_out <= unit_div ? div_hi : mul_hi;
        lo_out <= unit_div ? div_lo : mul_lo;
      end else if (fast0) begin
        hi_out <= req_srca;
        lo_out <= DIV0_LO;
      end
      if (busy && flush) begin
        drain_div <= (state == DIV_BUSY);
      end
    end
  end

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .run         (run),
    .ack         (ack),
    .expire      (expire),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural mul/div units with settable
// latency, a vector table, and hand sequences for flush/timeout/reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_mul, req_div, req_sign;
  logic [31:0] req_srca, req_srcb;
  logic        ex_hold, flush;
  logic        mul_in_valid, div_in_valid;
  logic        unit_sign;
  logic [31:0] unit_srca, unit_srcb;
  logic        mul_out_valid, div_out_valid;
  logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
  logic        stall, done, timeout_err;
  logic [31:0] hi_out, lo_out;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .TIMEOUT (8),
    .CNT_W   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_mul       (req_mul),
    .req_div       (req_div),
    .req_sign      (req_sign),
    .req_srca      (req_srca),
    .req_srcb      (req_srcb),
    .ex_hold       (ex_hold),
    .flush         (flush),
    .mul_in_valid  (mul_in_valid),
    .div_in_valid  (div_in_valid),
    .unit_sign     (unit_sign),
    .unit_srca     (unit_srca),
    .unit_srcb     (unit_srcb),
    .mul_out_valid (mul_out_valid),
    .mul_hi        (mul_hi),
    .mul_lo        (mul_lo),
    .div_out_valid (div_out_valid),
    .div_hi        (div_hi),
    .div_lo        (div_lo),
    .stall         (stall),
    .done          (done),
    .hi_out        (hi_out),
    .lo_out        (lo_out),
    .timeout_err   (timeout_err)
  );

  // Behavioural units: answer lat cycles after in_valid.
  int          lat = 1;
  logic        mute = 1'b0;
  int          mul_cd = 0;
  int          div_cd = 0;
  logic [63:0] mul_res = '0;
  logic [63:0] div_res = '0;

  function automatic logic [63:0] mul_calc(
    input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  function automatic logic [63:0] div_calc(
    input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  assign mul_out_valid = (mul_cd == 1);
  assign div_out_valid = (div_cd == 1);
  assign mul_hi = mul_res[63:32];
  assign mul_lo = mul_res[31:0];
  assign div_hi = div_res[63:32];
  assign div_lo = div_res[31:0];

  always @(posedge clk) begin
    if (mul_in_valid && !mute) begin
      mul_cd  <= lat;
      mul_res <= mul_calc(unit_sign, unit_srca, unit_srcb);
    end else if (mul_cd > 0) begin
      mul_cd <= mul_cd - 1;
    end
    if (div_in_valid && !mute) begin
      div_cd  <= lat;
      div_res <= div_calc(unit_sign, unit_srca, unit_srcb);
    end else if (div_cd > 0) begin
      div_cd <= div_cd - 1;
    end
  end

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h",
               nm, act, exp);
    end
  endtask

  // Per-cycle snapshots for the hand sequences.
  logic        s_dn[32], s_mi[32], s_di[32];
  logic        s_st[32], s_er[32];
  logic [31:0] s_hi[32], s_lo[32], s_sa[32];

  task automatic snap(input int c);
    @(negedge clk);
    s_dn[c] = done;
    s_mi[c] = mul_in_valid;
    s_di[c] = div_in_valid;
    s_st[c] = stall;
    s_er[c] = timeout_err;
    s_hi[c] = hi_out;
    s_lo[c] = lo_out;
    s_sa[c] = unit_srca;
    @(posedge clk);
    #1;
  endtask

  function automatic int sum_of(input logic arr[32],
                                input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) n += int'(arr[i]);
    return n;
  endfunction

  typedef struct {
    logic        rm, rd, sg;
    logic [31:0] a, b;
    int          lat, hold;
    int          done_at, stall_n, mul_n, div_n;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vt[8];

  task automatic run_vec(input vec_t v, input int idx);
    int          fd, n_st, n_mi, n_di, n_dn, last;
    logic [31:0] h, l;
    fd = -1; n_st = 0; n_mi = 0; n_di = 0; n_dn = 0;
    h = '0; l = '0;
    last = v.done_at + v.hold;
    lat = v.lat;
    for (int c = 0; c < last + 3; c++) begin
      req_mul  = v.rm && (c <= last);
      req_div  = v.rd && (c <= last);
      req_sign = v.sg;
      req_srca = v.a;
      req_srcb = v.b;
      ex_hold  = (c >= v.done_at) && (c < last);
      @(negedge clk);
      if (stall) n_st++;
      if (mul_in_valid) n_mi++;
      if (div_in_valid) n_di++;
      if (done) begin
        if (fd < 0) begin
          fd = c;
          h  = hi_out;
          l  = lo_out;
        end
        n_dn++;
      end
      @(posedge clk);
      #1;
    end
    req_mul = 1'b0;
    req_div = 1'b0;
    ex_hold = 1'b0;
    chk($sformatf("v%0d_done_at", idx), fd, v.done_at);
    chk($sformatf("v%0d_done_n", idx), n_dn, v.hold + 1);
    chk($sformatf("v%0d_stall_n", idx), n_st, v.stall_n);
    chk($sformatf("v%0d_mul_iv", idx), n_mi, v.mul_n);
    chk($sformatf("v%0d_div_iv", idx), n_di, v.div_n);
    chk($sformatf("v%0d_hi", idx), h, v.hi);
    chk($sformatf("v%0d_lo", idx), l, v.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit: got expired, want finished");
    $fatal(1);
  end

  initial begin
    // rm rd sg a b lat hold done_at stall mul div hi lo
    vt[0] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,
              3, 0, 5, 5, 1, 0,
              32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'd100, 32'd7,
              2, 3, 4, 4, 0, 1, 32'd2, 32'd14};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              1, 0, 3, 3, 1, 0,
              32'hFFFF_FFFE, 32'h0000_0001};
    vt[3] = '{1'b0, 1'b1, 1'b0, 32'd9, 32'd3,
              1, 0, 3, 3, 0, 1, 32'd0, 32'd3};
    vt[4] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7,
              2, 1, 4, 4, 1, 0,
              32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
              5, 0, 7, 7, 0, 1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD};
`ifdef MULDIV_DIV0_FAST_EN
    vt[6] = '{1'b0, 1'b1, 1'b0, 32'd5, 32'd0,
              2, 0, 1, 1, 0, 0, 32'd5, 32'hFFFF_FFFF};
`else
    vt[6] = '{1'b0, 1'b1, 1'b0, 32'd5, 32'd0,
              2, 0, 4, 4, 0, 1, 32'd5, 32'hFFFF_FFFF};
`endif
    vt[7] = '{1'b1, 1'b1, 1'b0, 32'd6, 32'd7,
              1, 0, 3, 3, 1, 0, 32'd0, 32'd42};

    rst = 1'b1;
    req_mul = 1'b0; req_div = 1'b0; req_sign = 1'b0;
    req_srca = '0; req_srcb = '0;
    ex_hold = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mul_iv", mul_in_valid, 0);
    chk("rst_div_iv", div_in_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_srca", unit_srca, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // Flush two cycles into a DIV, new MUL waits out the drain.
    for (int c = 0; c < 14; c++) begin
      lat      = (c < 5) ? 6 : 1;
      req_div  = (c < 3);
      flush    = (c == 3);
      req_mul  = (c >= 5) && (c <= 11);
      req_sign = 1'b0;
      req_srca = (c < 5) ? 32'd100 : 32'd3;
      req_srcb = (c < 5) ? 32'd7 : 32'd5;
      snap(c);
    end
    req_mul = 1'b0;
    flush   = 1'b0;
    chk("drain_stall", s_st[6], 1);
    chk("drain_hi_kept", s_hi[8], vt[7].hi);
    chk("drain_lo_kept", s_lo[8], vt[7].lo);
    chk("drain_no_done", sum_of(s_dn, 0, 10), 0);
    chk("drain_mul_iv_c8", s_mi[8], 0);
    chk("drain_mul_iv_c9", s_mi[9], 1);
    chk("drain_div_iv_n", sum_of(s_di, 0, 13), 1);
    chk("drain_next_done", s_dn[11], 1);
    chk("drain_next_lo", s_lo[11], 15);

    // Flush with out_valid, then flush in IDLE with a request.
    for (int c = 0; c < 11; c++) begin
      lat      = 2;
      req_div  = (c < 3);
      flush    = (c == 3) || (c == 8);
      req_mul  = (c == 8);
      req_srca = 32'd50;
      req_srcb = 32'd5;
      snap(c);
    end
    req_mul = 1'b0;
    flush   = 1'b0;
    chk("fv_no_done", sum_of(s_dn, 0, 10), 0);
    chk("fv_hi_kept", s_hi[7], 0);
    chk("fv_lo_kept", s_lo[7], 15);
    chk("idle_flush_stall", s_st[8], 0);
    chk("idle_flush_issue", sum_of(s_mi, 0, 10), 0);
    chk("fv_div_iv_n", sum_of(s_di, 0, 10), 1);

    // Flush while in DONE with ex_hold.
    for (int c = 0; c < 6; c++) begin
      lat      = 1;
      req_mul  = (c <= 3);
      ex_hold  = (c == 3);
      flush    = (c == 3);
      req_srca = 32'd4;
      req_srcb = 32'd4;
      snap(c);
    end
    req_mul = 1'b0;
    ex_hold = 1'b0;
    flush   = 1'b0;
    chk("dflush_done", s_dn[3], 1);
    chk("dflush_lo", s_lo[3], 16);
    chk("dflush_drop", s_dn[4], 0);
    chk("dflush_idle", s_dn[5], 0);

    // Unit never answers: watchdog, then a normal MUL.
    for (int c = 0; c < 15; c++) begin
      lat      = 1;
      mute     = (c < 9);
      req_mul  = (c <= 8) || ((c >= 10) && (c <= 13));
      req_srca = 32'd7;
      req_srcb = 32'd9;
      snap(c);
    end
    req_mul = 1'b0;
    mute    = 1'b0;
    chk("to_err_before", s_er[8], 0);
    chk("to_stall_before", s_st[8], 1);
    chk("to_err_set", s_er[9], 1);
    chk("to_no_done", sum_of(s_dn, 0, 12), 0);
    chk("to_mul_iv_n", sum_of(s_mi, 0, 14), 2);
    chk("to_reissue", s_mi[11], 1);
    chk("to_next_done", s_dn[13], 1);
    chk("to_next_lo", s_lo[13], 63);
    chk("to_sticky", s_er[14], 1);

    // Reset mid-operation; late out_valid is ignored.
    for (int c = 0; c < 9; c++) begin
      lat      = 4;
      req_mul  = (c <= 2);
      rst      = (c == 2);
      req_srca = 32'd2;
      req_srcb = 32'd3;
      snap(c);
    end
    req_mul = 1'b0;
    rst     = 1'b0;
    chk("mrst_hi", s_hi[3], 0);
    chk("mrst_err", s_er[3], 0);
    chk("mrst_srca", s_sa[3], 0);
    chk("mrst_no_done", sum_of(s_dn, 3, 8), 0);
    chk("mrst_no_issue", sum_of(s_mi, 3, 8), 0);
    chk("mrst_lo_kept", s_lo[8], 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
